regfile_write_sched: RTL

Write-port scheduler for the CPU register file. It shares the file's single write port between two requesters: ALU writeback (port 0) and load return (port 1), using valid/ready handshakes and round-robin arbitration. It also runs a clear sequence that zeroes every entry after reset or on request. It sits between the execute/memory stages and the register file's `write_addr_in` / `write_in` / `write_data_in` inputs.

---
 rtl/regfile_write_sched_pkg.sv | 5 +
 rtl/regfile_write_sched_if.sv | 29 ++
 rtl/regfile_write_sched_arb_rr2.sv | 22 ++
 rtl/regfile_write_sched.sv | 93 +++++++++
 4 files changed

// File: rtl/regfile_write_sched_pkg.sv
// regfile_sched_pkg: shared state type and counter width for the write scheduler
package regfile_sched_pkg;
  typedef enum logic {CLEAR, RUN} sched_state_t;
  localparam int DROP_CNT_W = 8;
endpackage

// File: rtl/regfile_write_sched_if.sv
// regfile_write_sched_if: requester handshakes, register-file write port and status
interface regfile_write_sched_if;
  import regfile_sched_pkg::*;
  logic                  init_in;
  logic                  wb_valid_in;
  logic [31:0]           wb_addr_in;
  logic [31:0]           wb_data_in;
  logic                  wb_ready_out;
  logic                  ld_valid_in;
  logic [31:0]           ld_addr_in;
  logic [31:0]           ld_data_in;
  logic                  ld_ready_out;
  logic [31:0]           write_addr_out;
  logic                  write_out;
  logic [31:0]           write_data_out;
  logic                  busy_out;
  logic                  range_err_out;
  logic [DROP_CNT_W-1:0] drop_count_out;
  modport slave (
    input  init_in, wb_valid_in, wb_addr_in, wb_data_in, ld_valid_in, ld_addr_in, ld_data_in,
    output wb_ready_out, ld_ready_out, write_addr_out, write_out, write_data_out,
    output busy_out, range_err_out, drop_count_out
  );
  modport master (
    output init_in, wb_valid_in, wb_addr_in, wb_data_in, ld_valid_in, ld_addr_in, ld_data_in,
    input  wb_ready_out, ld_ready_out, write_addr_out, write_out, write_data_out,
    input  busy_out, range_err_out, drop_count_out
  );
endinterface

// File: rtl/regfile_write_sched_arb_rr2.sv
// arb_rr2: two-requester round-robin arbiter; last_q holds the most recently granted port
module arb_rr2 (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic enable,
  output logic grant0,
  output logic grant1
);
  logic last_q, last_d;
  // grants depend only on the other requester and last; last moves only on a transfer
  always_comb begin
    grant0 = enable && (!valid1 || last_q);
    grant1 = enable && (!valid0 || !last_q);
    last_d = (valid0 && grant0) ? 1'b0 : (valid1 && grant1) ? 1'b1 : last_q;
  end
  // last resets to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
endmodule

// File: rtl/regfile_write_sched.sv
// regfile_write_sched: shares the register-file write port between ALU writeback and load return
module regfile_write_sched
  import regfile_sched_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input logic clk,
  input logic reset,
  regfile_write_sched_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  sched_state_t          state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [31:0]           waddr_q, waddr_d, wdata_q, wdata_d;
  logic                  busy_q, busy_d, rerr_q, rerr_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  run, g0, g1, x0, x1, acc, oor, zero;
  logic [31:0]           a, dat;
  assign run = (state_q == RUN) && !bus.init_in;
  arb_rr2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (bus.wb_valid_in),
    .valid1 (bus.ld_valid_in),
    .enable (run),
    .grant0 (g0),
    .grant1 (g1)
  );
  // counter runs one past DEPTH-1 so the last clear write is visible while still busy
  always_comb begin
    x0      = g0 && bus.wb_valid_in;
    x1      = g1 && bus.ld_valid_in;
    acc     = x0 || x1;
    a       = x0 ? bus.wb_addr_in : bus.ld_addr_in;
    dat     = x0 ? bus.wb_data_in : bus.ld_data_in;
    oor     = a >= 32'(DEPTH);
    zero    = ZERO_DISCARD && (a == 32'd0);
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = 1'b0;
    waddr_d = 32'd0;
    wdata_d = 32'd0;
    if (bus.init_in) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else if (state_q == CLEAR) begin
      if (cnt_q == CW'(DEPTH)) state_d = RUN;
      else begin
        write_d = 1'b1;
        waddr_d = 32'(cnt_q);
        cnt_d   = cnt_q + 1'b1;
      end
    end else if (acc && !oor && !zero) begin
      write_d = 1'b1;
      waddr_d = a;
      wdata_d = dat;
    end
    busy_d = state_d == CLEAR;
    rerr_d = rerr_q || (acc && oor);
    drop_d = (acc && (oor || zero) && drop_q != '1) ? drop_q + DROP_CNT_W'(1) : drop_q;
  end
  // all state, including any in-flight write, is dropped on reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      write_q <= 1'b0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b1;
      rerr_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      rerr_q  <= rerr_d;
      drop_q  <= drop_d;
    end
  assign bus.wb_ready_out   = g0;
  assign bus.ld_ready_out   = g1;
  assign bus.write_out      = write_q;
  assign bus.write_addr_out = waddr_q;
  assign bus.write_data_out = wdata_q;
  assign bus.busy_out       = busy_q;
  assign bus.range_err_out  = rerr_q;
  assign bus.drop_count_out = drop_q;
endmodule
